// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle processor control FSM with memory wait timeout
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB for a small MIPS-like
// instruction subset, drives the datapath control lines, times out stalled
// memory accesses and counts retired instructions.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          leave IDLE and begin fetching
//   opcode_i         instruction opcode, sampled in DECODE only
//   zero_i           ALU zero flag (beq)
//   mem_ready_i      memory completes the current request this cycle
//   *_o controls     pc_write, ir_write, mem_req, mem_we, i_or_d, reg_write,
//                    reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0],
//                    alu_op[2:0], pc_src[1:0]
//   busy_o           high in every state except IDLE
//   err_code_o       01 illegal opcode, 10 memory timeout (ERROR only)
//   instr_count_o    saturating count of completed instructions
module multicycle_control #(
   parameter int OPCODE_LENGTH = 6,
   parameter int MEM_TIMEOUT   = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic [OPCODE_LENGTH-1:0] opcode_i,
   input  logic                     zero_i,
   input  logic                     mem_ready_i,
   output logic                     pc_write_o,
   output logic                     ir_write_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic                     i_or_d_o,
   output logic                     reg_write_o,
   output logic                     reg_dst_o,
   output logic                     mem_to_reg_o,
   output logic                     alu_src_a_o,
   output logic [1:0]               alu_src_b_o,
   output logic [2:0]               alu_op_o,
   output logic [1:0]               pc_src_o,
   output logic                     busy_o,
   output logic [1:0]               err_code_o,
   output logic [15:0]              instr_count_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   localparam logic [OPCODE_LENGTH-1:0] OP_RTYPE = OPCODE_LENGTH'(6'b000000);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADDI  = OPCODE_LENGTH'(6'b001000);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADDIU = OPCODE_LENGTH'(6'b001001);
   localparam logic [OPCODE_LENGTH-1:0] OP_LW    = OPCODE_LENGTH'(6'b100011);
   localparam logic [OPCODE_LENGTH-1:0] OP_SW    = OPCODE_LENGTH'(6'b101011);
   localparam logic [OPCODE_LENGTH-1:0] OP_BEQ   = OPCODE_LENGTH'(6'b000100);
   localparam logic [OPCODE_LENGTH-1:0] OP_J     = OPCODE_LENGTH'(6'b000010);
   localparam logic [OPCODE_LENGTH-1:0] OP_HALT  = OPCODE_LENGTH'(6'b111111);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [2:0]               state_q, state_d;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic [WAIT_W-1:0]        wait_q, wait_d;
   logic [1:0]               err_q, err_d;
   logic [15:0]              cnt_q, cnt_d;
   logic                     cnt_inc;
   logic                     op_legal;
   logic                     wait_expired;

   always_comb begin
      op_legal = (opcode_i == OP_RTYPE) || (opcode_i == OP_ADDI) ||
                 (opcode_i == OP_ADDIU) || (opcode_i == OP_LW)   ||
                 (opcode_i == OP_SW)    || (opcode_i == OP_BEQ)  ||
                 (opcode_i == OP_J);
   end

   // This cycle is the MEM_TIMEOUT-th consecutive stall; mem_ready_i is
   // tested first below so a late completion still wins.
   assign wait_expired = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wait_d  = '0;
      err_d   = err_q;
      cnt_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready_i) begin
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_ERROR;
               err_d   = 2'b10;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            op_d = opcode_i;
            if (op_legal) begin
               state_d = S_EXEC;
            end else if (opcode_i == OP_HALT) begin
               state_d = S_IDLE;
               cnt_inc = 1'b1;
            end else begin
               state_d = S_ERROR;
               err_d   = 2'b01;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_RTYPE, OP_ADDI, OP_ADDIU: state_d = S_WB;
               OP_LW, OP_SW:                state_d = S_MEM;
               default: begin
                  state_d = S_FETCH;
                  cnt_inc = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ready_i) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  cnt_inc = 1'b1;
               end
            end else if (wait_expired) begin
               state_d = S_ERROR;
               err_d   = 2'b10;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            cnt_inc = 1'b1;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
      cnt_d = (cnt_inc && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         wait_q  <= '0;
         err_q   <= 2'b00;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      i_or_d_o     = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      pc_src_o     = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req_o   = 1'b1;
            alu_src_b_o = 2'b01;
            alu_op_o    = 3'b001;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            alu_op_o    = 3'b001;
         end
         S_EXEC: begin
            case (op_q)
               OP_RTYPE: begin
                  alu_src_a_o = 1'b1;
                  alu_op_o    = 3'b100;
               end
               OP_ADDI, OP_LW, OP_SW: begin
                  alu_src_a_o = 1'b1;
                  alu_src_b_o = 2'b10;
                  alu_op_o    = 3'b001;
               end
               OP_ADDIU: begin
                  alu_src_a_o = 1'b1;
                  alu_src_b_o = 2'b10;
                  alu_op_o    = 3'b010;
               end
               OP_BEQ: begin
                  alu_src_a_o = 1'b1;
                  alu_op_o    = 3'b011;
                  pc_src_o    = 2'b01;
                  pc_write_o  = zero_i;
               end
               OP_J: begin
                  pc_write_o = 1'b1;
                  pc_src_o   = 2'b10;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req_o = 1'b1;
            i_or_d_o  = 1'b1;
            mem_we_o  = (op_q == OP_SW);
         end
         S_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = (op_q == OP_RTYPE);
            mem_to_reg_o = (op_q == OP_LW);
         end
         default: ;
      endcase
   end

   assign busy_o        = (state_q != S_IDLE);
   assign err_code_o    = (state_q == S_ERROR) ? err_q : 2'b00;
   assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, zero_i, mem_ready_i;
   logic [5:0]  opcode_i;
   logic        pc_write_o, ir_write_o, mem_req_o, mem_we_o, i_or_d_o;
   logic        reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, busy_o;
   logic [1:0]  alu_src_b_o, pc_src_o, err_code_o;
   logic [2:0]  alu_op_o;
   logic [15:0] instr_count_o;

   multicycle_control #(.OPCODE_LENGTH(6), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .opcode_i(opcode_i),
      .zero_i(zero_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .i_or_d_o(i_or_d_o), .reg_write_o(reg_write_o),
      .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .busy_o(busy_o),
      .err_code_o(err_code_o), .instr_count_o(instr_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy, pcw, irw, mreq, mwe, iod, rw, rdst, m2r, srca;
      logic [1:0]  srcb;
      logic [2:0]  aop;
      logic [1:0]  psrc;
      logic [1:0]  err;
      logic [15:0] cnt;
   } out_t;

   typedef struct {
      logic       st;
      logic [5:0] opc;
      logic       z;
      logic       rdy;
      out_t       exp;
   } vec_t;

   typedef enum int {PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB, PH_ERROR} phase_t;
   typedef enum int {C_R, C_ADDI, C_ADDIU, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_BAD} cls_t;

   int     vectors = 0;
   int     miscompares = 0;
   phase_t m_ph;
   cls_t   m_cls;
   int     m_wait, m_cnt, m_err;
   vec_t   tbl[$];
   logic [5:0] legal_ops [7] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02};

   function automatic cls_t classify(input logic [5:0] opc);
      case (opc)
         6'h00: return C_R;
         6'h08: return C_ADDI;
         6'h09: return C_ADDIU;
         6'h23: return C_LW;
         6'h2B: return C_SW;
         6'h04: return C_BEQ;
         6'h02: return C_J;
         6'h3F: return C_HALT;
         default: return C_BAD;
      endcase
   endfunction

   // flags order: pcw irw mreq mwe iod rw rdst m2r srca
   function automatic vec_t v(input logic st, input logic [5:0] opc, input logic z,
                              input logic rdy, input logic busy, input logic [8:0] fl,
                              input logic [1:0] srcb, input logic [2:0] aop,
                              input logic [1:0] psrc, input logic [1:0] err,
                              input logic [15:0] cnt);
      vec_t r;
      r.st = st; r.opc = opc; r.z = z; r.rdy = rdy;
      r.exp = {busy, fl, srcb, aop, psrc, err, cnt};
      return r;
   endfunction

   function automatic out_t dut_out();
      return {busy_o, pc_write_o, ir_write_o, mem_req_o, mem_we_o, i_or_d_o,
              reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
              alu_op_o, pc_src_o, err_code_o, instr_count_o};
   endfunction

   // Expected outputs for the model's current phase and the live inputs.
   function automatic out_t model_out();
      out_t o = '0;
      o.cnt = 16'(m_cnt);
      case (m_ph)
         PH_FETCH: begin
            o.busy = 1; o.mreq = 1; o.srcb = 2'b01; o.aop = 3'b001;
            o.irw = mem_ready_i; o.pcw = mem_ready_i;
         end
         PH_DECODE: begin o.busy = 1; o.srcb = 2'b11; o.aop = 3'b001; end
         PH_EXEC: begin
            o.busy = 1;
            case (m_cls)
               C_R:     begin o.srca = 1; o.aop = 3'b100; end
               C_ADDIU: begin o.srca = 1; o.srcb = 2'b10; o.aop = 3'b010; end
               C_BEQ:   begin o.srca = 1; o.aop = 3'b011; o.psrc = 2'b01; o.pcw = zero_i; end
               C_J:     begin o.pcw = 1; o.psrc = 2'b10; end
               default: begin o.srca = 1; o.srcb = 2'b10; o.aop = 3'b001; end
            endcase
         end
         PH_MEM: begin o.busy = 1; o.mreq = 1; o.iod = 1; o.mwe = (m_cls == C_SW); end
         PH_WB: begin
            o.busy = 1; o.rw = 1; o.rdst = (m_cls == C_R); o.m2r = (m_cls == C_LW);
         end
         PH_ERROR: begin o.busy = 1; o.err = 2'(m_err); end
         default: ;
      endcase
      return o;
   endfunction

   task automatic bump();
      if (m_cnt < 65535) m_cnt++;
   endtask

   task automatic mem_wait();
      if (m_wait + 1 >= TIMEOUT) begin
         m_ph = PH_ERROR; m_err = 2; m_wait = 0;
      end else begin
         m_wait++;
      end
   endtask

   task automatic model_step();
      cls_t c;
      case (m_ph)
         PH_IDLE: if (start_i) m_ph = PH_FETCH;
         PH_FETCH: begin
            if (mem_ready_i) begin m_ph = PH_DECODE; m_wait = 0; end
            else mem_wait();
         end
         PH_DECODE: begin
            c = classify(opcode_i);
            if (c == C_HALT) begin m_ph = PH_IDLE; bump(); end
            else if (c == C_BAD) begin m_ph = PH_ERROR; m_err = 1; end
            else begin m_cls = c; m_ph = PH_EXEC; end
         end
         PH_EXEC: begin
            if (m_cls inside {C_R, C_ADDI, C_ADDIU}) m_ph = PH_WB;
            else if (m_cls inside {C_LW, C_SW}) m_ph = PH_MEM;
            else begin m_ph = PH_FETCH; bump(); end
         end
         PH_MEM: begin
            if (mem_ready_i) begin
               m_wait = 0;
               if (m_cls == C_LW) m_ph = PH_WB;
               else begin m_ph = PH_FETCH; bump(); end
            end else mem_wait();
         end
         PH_WB: begin m_ph = PH_FETCH; bump(); end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_ph = PH_IDLE; m_cls = C_R; m_wait = 0; m_cnt = 0; m_err = 0;
   endtask

   task automatic cmp(input string name, input out_t act, input out_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive inputs just after a rising edge, check the outputs mid-cycle.
   task automatic apply(input logic st, input logic [5:0] opc, input logic z, input logic rdy);
      start_i = st; opcode_i = opc; zero_i = z; mem_ready_i = rdy;
      @(negedge clk);
      cmp("model", dut_out(), model_out());
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      cmp("reset_model", dut_out(), model_out());
      chk("reset_count", 32'(instr_count_o), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int rdy_pct;
      int err_cycles;
      int idx;
      logic [5:0] opc;

      rst_n = 1'b0; start_i = 0; opcode_i = 0; zero_i = 0; mem_ready_i = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      cmp("reset_state", dut_out(), '0);
      rst_n = 1'b1;
      apply(0, 6'h08, 0, 1); advance();
      apply(0, 6'h08, 0, 1); advance();

      // st opc z rdy | busy flags(pcw irw mreq mwe iod rw rdst m2r srca) srcb aop psrc err cnt
      tbl.push_back(v(1, 6'h00, 0, 0, 0, 9'b000000000, 2'b00, 3'b000, 2'b00, 2'b00, 0));
      tbl.push_back(v(0, 6'h08, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 0));
      tbl.push_back(v(0, 6'h08, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 0));
      tbl.push_back(v(0, 6'h08, 0, 0, 1, 9'b000000001, 2'b10, 3'b001, 2'b00, 2'b00, 0));
      tbl.push_back(v(0, 6'h08, 0, 0, 1, 9'b000001000, 2'b00, 3'b000, 2'b00, 2'b00, 0));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b001000000, 2'b01, 3'b001, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b000000001, 2'b10, 3'b001, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b001010000, 2'b00, 3'b000, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b001010000, 2'b00, 3'b000, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b001010000, 2'b00, 3'b000, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 1, 1, 9'b001010000, 2'b00, 3'b000, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h23, 0, 0, 1, 9'b000001010, 2'b00, 3'b000, 2'b00, 2'b00, 1));
      tbl.push_back(v(0, 6'h04, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 2));
      tbl.push_back(v(0, 6'h04, 1, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 2));
      tbl.push_back(v(0, 6'h04, 1, 0, 1, 9'b100000001, 2'b00, 3'b011, 2'b01, 2'b00, 2));
      tbl.push_back(v(0, 6'h04, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 3));
      tbl.push_back(v(0, 6'h04, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 3));
      tbl.push_back(v(0, 6'h04, 0, 0, 1, 9'b000000001, 2'b00, 3'b011, 2'b01, 2'b00, 3));
      tbl.push_back(v(0, 6'h2B, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 4));
      tbl.push_back(v(0, 6'h2B, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 4));
      tbl.push_back(v(0, 6'h2B, 0, 0, 1, 9'b000000001, 2'b10, 3'b001, 2'b00, 2'b00, 4));
      tbl.push_back(v(0, 6'h2B, 0, 1, 1, 9'b001110000, 2'b00, 3'b000, 2'b00, 2'b00, 4));
      tbl.push_back(v(0, 6'h00, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 5));
      tbl.push_back(v(0, 6'h00, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 5));
      tbl.push_back(v(0, 6'h00, 0, 0, 1, 9'b000000001, 2'b00, 3'b100, 2'b00, 2'b00, 5));
      tbl.push_back(v(0, 6'h00, 0, 0, 1, 9'b000001100, 2'b00, 3'b000, 2'b00, 2'b00, 5));
      tbl.push_back(v(0, 6'h09, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 6));
      tbl.push_back(v(0, 6'h09, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 6));
      tbl.push_back(v(0, 6'h09, 0, 0, 1, 9'b000000001, 2'b10, 3'b010, 2'b00, 2'b00, 6));
      tbl.push_back(v(0, 6'h09, 0, 0, 1, 9'b000001000, 2'b00, 3'b000, 2'b00, 2'b00, 6));
      tbl.push_back(v(0, 6'h02, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 7));
      tbl.push_back(v(0, 6'h02, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 7));
      tbl.push_back(v(0, 6'h02, 0, 0, 1, 9'b100000000, 2'b00, 3'b000, 2'b10, 2'b00, 7));
      tbl.push_back(v(0, 6'h3F, 0, 1, 1, 9'b111000000, 2'b01, 3'b001, 2'b00, 2'b00, 8));
      tbl.push_back(v(0, 6'h3F, 0, 0, 1, 9'b000000000, 2'b11, 3'b001, 2'b00, 2'b00, 8));
      tbl.push_back(v(0, 6'h00, 0, 0, 0, 9'b000000000, 2'b00, 3'b000, 2'b00, 2'b00, 9));
      tbl.push_back(v(0, 6'h00, 0, 1, 0, 9'b000000000, 2'b00, 3'b000, 2'b00, 2'b00, 9));

      foreach (tbl[i]) begin
         apply(tbl[i].st, tbl[i].opc, tbl[i].z, tbl[i].rdy);
         cmp($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
         advance();
      end

      // Fetch stall expiring after 15 waiting cycles, then ERROR is sticky.
      apply(1, 6'h00, 0, 0); advance();
      for (int i = 1; i <= TIMEOUT; i++) begin
         apply(0, 6'h00, 0, 0);
         if (i == TIMEOUT) chk("timeout_last_fetch_mreq", 32'(mem_req_o), 1);
         advance();
      end
      apply(1, 6'h00, 0, 1);
      chk("timeout_err", 32'(err_code_o), 2);
      chk("timeout_mreq", 32'(mem_req_o), 0);
      chk("timeout_busy", 32'(busy_o), 1);
      advance();
      apply(1, 6'h08, 0, 1);
      chk("timeout_sticky", 32'(err_code_o), 2);
      advance();
      do_reset();

      // mem_ready on the 15th cycle wins, then an illegal opcode.
      apply(1, 6'h00, 0, 0); advance();
      for (int i = 1; i < TIMEOUT; i++) begin
         apply(0, 6'h00, 0, 0); advance();
      end
      apply(0, 6'h15, 0, 1);
      chk("late_ready_irw", 32'(ir_write_o), 1);
      advance();
      apply(0, 6'h15, 0, 0);
      chk("late_ready_decode_srcb", 32'(alu_src_b_o), 3);
      chk("late_ready_no_err", 32'(err_code_o), 0);
      advance();
      apply(1, 6'h00, 0, 1);
      chk("illegal_err", 32'(err_code_o), 1);
      advance();
      apply(1, 6'h00, 0, 1);
      chk("illegal_sticky_busy", 32'(busy_o), 1);
      chk("illegal_sticky_err", 32'(err_code_o), 1);
      advance();
      do_reset();
      apply(0, 6'h00, 0, 0);
      chk("after_reset_busy", 32'(busy_o), 0);
      advance();

      // Asynchronous reset while a load is stalled in MEM.
      apply(1, 6'h23, 0, 0); advance();
      apply(0, 6'h23, 0, 1); advance();
      apply(0, 6'h23, 0, 0); advance();
      apply(0, 6'h23, 0, 0); advance();
      apply(0, 6'h23, 0, 0);
      chk("mid_mem_mreq", 32'(mem_req_o), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_mreq", 32'(mem_req_o), 0);
      chk("rst_mid_mem_iod", 32'(i_or_d_o), 0);
      chk("rst_mid_mem_busy", 32'(busy_o), 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(0, 6'h23, 0, 1); advance();
      apply(0, 6'h23, 0, 1); advance();

      // Randomized traffic against the reference model.
      rdy_pct = 90;
      err_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: rdy_pct = 5;
               1: rdy_pct = 50;
               default: rdy_pct = 90;
            endcase
         end
         idx = $urandom_range(0, 9);
         if (idx < 7) opc = legal_ops[idx];
         else if (idx == 7) opc = 6'h3F;
         else opc = 6'($urandom);
         apply(1'($urandom_range(0, 1)), opc, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < rdy_pct));
         advance();
         if (m_ph == PH_ERROR) err_cycles++;
         else err_cycles = 0;
         if (err_cycles >= 3 || $urandom_range(0, 399) == 0) begin
            do_reset();
            err_cycles = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
